sprite_scheduler: RTL and testbench
===================================

// Module: sprite_scheduler
// PURPOSE
//  Upstream sequencer for the sprite renderer. Holds a table of sprite descriptors (x, y, scale, sprite id).
//  On each frame_start it walks the table in index order and loads one descriptor into the renderer.
//  For each sprite it pulses the renderer's reset, holds enable until finished, then advances to the next entry.
//  Sits between the game-logic register interface and the renderer/framebuffer write path.
// PARAMETERS
//  NUM_SPRITES  16   table depth; index width IDXW = $clog2(NUM_SPRITES)
//  CORDW        10   screen coordinate width
//  SPR_IDW      4    sprite-ROM select width
//  SCREEN_W     800  visible width, used for culling
//  SCREEN_H     480  visible height, used for culling
// PORTS
//  clk              in   1        system clock
//  rst              in   1        synchronous, active-low reset
//  frame_start      in   1        1-cycle pulse (vblank), starts a table walk
//  wr_en            in   1        table write strobe
//  wr_idx           in   IDXW     entry to write
//  wr_valid         in   1        entry valid bit
//  wr_id            in   SPR_IDW  sprite ROM select
//  wr_x, wr_y       in   CORDW    sprite top-left position
//  wr_scale         in   8        scale byte; also the output size in px
//  render_rst       out  1        active-high reset pulse to the renderer
//  render_en        out  1        renderer enable
//  render_finished  in   1        renderer finished flag; sticky until render_rst
//  spr_x, spr_y     out  CORDW    latched position for the current sprite
//  spr_scale        out  8        latched scale for the current sprite
//  spr_id           out  SPR_IDW  latched ROM select for the current sprite
//  busy             out  1        high while the walk is in progress
//  frame_done       out  1        1-cycle pulse when the walk completes
//  overrun          out  1        sticky: frame_start arrived while busy
//  sprites_drawn    out  IDXW+1   count of sprites rendered in the last walk
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): all outputs are 0, state is IDLE, and every table valid bit is 0.
//  - All outputs are registered.
//  - Table writes land the cycle after wr_en and are accepted in any state.
//  - Each descriptor is latched at FETCH, so a write never disturbs the sprite currently being drawn.
//  - States: IDLE, FETCH, CLEAR, DRAW, NEXT.
//    IDLE: on frame_start: idx<=0, busy<=1, sprites_drawn<=0, go to FETCH.
//    FETCH: table[idx] is drawable when valid && scale!=0 (see CONFIGURATION).
//           If drawable: latch spr_* and render_rst<=1, go to CLEAR. Otherwise go to NEXT.
//    CLEAR: render_rst<=0, render_en<=1, go to DRAW.
//           The renderer's stale finished flag clears during this cycle.
//    DRAW: hold render_en=1. When render_finished==1: render_en<=0, sprites_drawn++, go to NEXT.
//    NEXT: if idx==NUM_SPRITES-1: busy<=0, frame_done<=1 for one cycle, go to IDLE.
//          Otherwise idx++ and go to FETCH.
//  - Per-sprite overhead is 3 cycles (FETCH, CLEAR, NEXT) plus the renderer time. A skipped entry costs 2 cycles.
//  - frame_start while busy: ignored and overrun<=1; overrun stays set until reset.
//  - frame_start in the same cycle as the frame_done transition (NEXT->IDLE): ignored, overrun set.
//  - wr_en to idx in the same cycle as FETCH of that idx: FETCH sees the old value.
//  - Reset mid-DRAW: render_en and render_rst drop next cycle. The renderer is re-reset before its next use.
//  - spr_* hold their last value outside DRAW.
//  - render_rst is never high in the same cycle as render_en.
// CONFIGURATION
//  SPRITE_SCHED_CULL_EN defined:
//    FETCH also requires x < SCREEN_W and y < SCREEN_H, computed at CORDW+1 bits.
//    Off-screen entries are skipped like invalid ones.
//  SPRITE_SCHED_CULL_EN undefined:
//    No position check. Off-screen sprites are issued to the renderer, which suppresses the out-of-range pixels itself.
// STRUCTURE
//  sprite_pkg:
//    - sprite_desc_t struct {valid, id, x, y, scale}
//    - sched_state_t enum
//    - SCREEN_W/SCREEN_H constants, shared with the renderer and framebuffer
//  Sub-module sprite_desc_table: register array with 1 write port and 1 async read port indexed by idx.
//  The FSM, output latches and counters live in the top module.
// TESTING
//  1. Reset, then frame_start with an empty table -> frame_done 2*NUM_SPRITES+1 cycles later, sprites_drawn=0, render_rst never high.
//  2. Entry 3 = {x=100,y=50,scale=16,id=2}; renderer model finishes after 256 cycles -> spr_x=100, spr_y=50;
//     render_rst pulses 1 cycle, then render_en holds for 256 cycles; sprites_drawn=1.
//  3. Entries 0 and 15 valid with scale 8 -> two render_rst pulses, in index order; frame_done once; busy low afterwards.
//  4. Entry with scale=0 and valid=1 -> skipped, no render_rst.
//     frame_start injected mid-walk -> overrun=1 and the walk is unaffected.
//  5. Overwrite entry 2 with x=300 during DRAW of entry 2 -> spr_x stays at the old value;
//     the next frame_start issues x=300.
//  6. Entry x=820, y=10, scale 16: with SPRITE_SCHED_CULL_EN -> skipped;
//     without it -> issued to the renderer. Also assert rst low mid-DRAW -> render_en=0 next cycle, busy=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite types and screen geometry for scheduler, renderer and framebuffer.
// Culling of off-screen entries is enabled by defining SPRITE_SCHED_CULL_EN.
package sprite_pkg;

    localparam int CORDW    = 10;
    localparam int SPR_IDW  = 4;
    localparam int SCALEW   = 8;
    localparam int SCREEN_W = 800;
    localparam int SCREEN_H = 480;

    typedef struct packed {
        logic               valid;
        logic [SPR_IDW-1:0] id;
        logic [CORDW-1:0]   x;
        logic [CORDW-1:0]   y;
        logic [SCALEW-1:0]  scale;
    } sprite_desc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CLEAR,
        ST_DRAW,
        ST_NEXT
    } sched_state_t;

    // Compared one bit wider so SCREEN_W/H never truncate.
    function automatic logic on_screen(input sprite_desc_t d);
        logic [CORDW:0] xw;
        logic [CORDW:0] yw;
        xw = {1'b0, d.x};
        yw = {1'b0, d.y};
        return (xw < (CORDW+1)'(SCREEN_W)) && (yw < (CORDW+1)'(SCREEN_H));
    endfunction

endpackage

// File: rtl/sprite_desc_table.sv
// Sprite descriptor table: one synchronous write port, one async read port.
// Reset clears only the valid bits; payload fields are don't-care until written.
module sprite_desc_table
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 16,
    localparam int IDXW = $clog2(NUM_SPRITES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  sprite_desc_t wr_desc,
    input  logic [IDXW-1:0] rd_idx,
    output sprite_desc_t rd_desc
);

    sprite_desc_t table_q [NUM_SPRITES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                table_q[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            table_q[wr_idx] <= wr_desc;
        end
    end

    assign rd_desc = table_q[rd_idx];

endmodule

// File: rtl/sprite_scheduler.sv
// Walks the sprite table once per frame and sequences the renderer per entry.
// Define SPRITE_SCHED_CULL_EN to skip entries whose position is off-screen.
module sprite_scheduler
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 16,
    localparam int IDXW = $clog2(NUM_SPRITES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               wr_en,
    input  logic [IDXW-1:0]    wr_idx,
    input  logic               wr_valid,
    input  logic [SPR_IDW-1:0] wr_id,
    input  logic [CORDW-1:0]   wr_x,
    input  logic [CORDW-1:0]   wr_y,
    input  logic [7:0]         wr_scale,
    output logic               render_rst,
    output logic               render_en,
    input  logic               render_finished,
    output logic [CORDW-1:0]   spr_x,
    output logic [CORDW-1:0]   spr_y,
    output logic [7:0]         spr_scale,
    output logic [SPR_IDW-1:0] spr_id,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun,
    output logic [IDXW:0]      sprites_drawn
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_SPRITES - 1);

    sched_state_t state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic [IDXW:0]      cnt_q, cnt_d;
    logic               rrst_q, rrst_d;
    logic               ren_q, ren_d;
    logic [CORDW-1:0]   x_q, x_d;
    logic [CORDW-1:0]   y_q, y_d;
    logic [7:0]         scale_q, scale_d;
    logic [SPR_IDW-1:0] id_q, id_d;

    sprite_desc_t wr_desc;
    sprite_desc_t rd_desc;
    logic         drawable;

    assign wr_desc = '{valid: wr_valid, id: wr_id, x: wr_x,
                       y: wr_y, scale: wr_scale};

    sprite_desc_table #(
        .NUM_SPRITES(NUM_SPRITES)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_idx (wr_idx),
        .wr_desc(wr_desc),
        .rd_idx (idx_q),
        .rd_desc(rd_desc)
    );

`ifdef SPRITE_SCHED_CULL_EN
    assign drawable = rd_desc.valid && (rd_desc.scale != '0)
                      && on_screen(rd_desc);
`else
    assign drawable = rd_desc.valid && (rd_desc.scale != '0);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;
        rrst_d  = 1'b0;
        ren_d   = ren_q;
        x_d     = x_q;
        y_d     = y_q;
        scale_d = scale_q;
        id_d    = id_q;

        // Includes the NEXT->IDLE cycle, where busy is still high.
        if (frame_start && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (drawable) begin
                    x_d     = rd_desc.x;
                    y_d     = rd_desc.y;
                    scale_d = rd_desc.scale;
                    id_d    = rd_desc.id;
                    rrst_d  = 1'b1;
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_CLEAR: begin
                ren_d   = 1'b1;
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (render_finished) begin
                    ren_d   = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
            rrst_q  <= 1'b0;
            ren_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            scale_q <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
            rrst_q  <= rrst_d;
            ren_q   <= ren_d;
            x_q     <= x_d;
            y_q     <= y_d;
            scale_q <= scale_d;
            id_q    <= id_d;
        end
    end

    assign render_rst    = rrst_q;
    assign render_en     = ren_q;
    assign spr_x         = x_q;
    assign spr_y         = y_q;
    assign spr_scale     = scale_q;
    assign spr_id        = id_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign overrun       = ovr_q;
    assign sprites_drawn = cnt_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler with a simple renderer model.
// Expectations for the cull case follow SPRITE_SCHED_CULL_EN.
module tb_sprite_scheduler;

    localparam int N    = 16;
    localparam int IDXW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic       wr_valid;
    logic [3:0] wr_id;
    logic [9:0] wr_x;
    logic [9:0] wr_y;
    logic [7:0] wr_scale;
    logic       render_rst;
    logic       render_en;
    logic       render_finished;
    logic [9:0] spr_x;
    logic [9:0] spr_y;
    logic [7:0] spr_scale;
    logic [3:0] spr_id;
    logic       busy;
    logic       frame_done;
    logic       overrun;
    logic [4:0] sprites_drawn;

    int n_chk = 0;
    int n_err = 0;

    sprite_scheduler #(.NUM_SPRITES(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .wr_en          (wr_en),
        .wr_idx         (wr_idx),
        .wr_valid       (wr_valid),
        .wr_id          (wr_id),
        .wr_x           (wr_x),
        .wr_y           (wr_y),
        .wr_scale       (wr_scale),
        .render_rst     (render_rst),
        .render_en      (render_en),
        .render_finished(render_finished),
        .spr_x          (spr_x),
        .spr_y          (spr_y),
        .spr_scale      (spr_scale),
        .spr_id         (spr_id),
        .busy           (busy),
        .frame_done     (frame_done),
        .overrun        (overrun),
        .sprites_drawn  (sprites_drawn)
    );

    always #5 clk = ~clk;

    // Renderer model: finished rises so that render_en stays high rlat cycles.
    int rlat = 8;
    int rcnt = 0;
    logic rfin = 1'b0;
    assign render_finished = rfin;

    always @(posedge clk) begin
        if (render_rst) begin
            rcnt <= 0;
            rfin <= 1'b0;
        end else if (render_en && !rfin) begin
            rcnt <= rcnt + 1;
            if (rcnt + 1 == rlat - 1) rfin <= 1'b1;
        end
    end

    int n_rrst = 0;
    int n_ren  = 0;
    int n_done = 0;
    int n_ovl  = 0;
    int qx[$];
    int qy[$];
    int qid[$];

    always @(negedge clk) begin
        if (render_rst) begin
            n_rrst <= n_rrst + 1;
            qx.push_back(int'(spr_x));
            qy.push_back(int'(spr_y));
            qid.push_back(int'(spr_id));
        end
        if (render_en) n_ren <= n_ren + 1;
        if (frame_done) n_done <= n_done + 1;
        if (render_rst && render_en) n_ovl <= n_ovl + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic write_entry(input int idx, input logic v, input int id,
                               input int x, input int y, input int sc);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_idx   = 4'(idx);
        wr_valid = v;
        wr_id    = 4'(id);
        wr_x     = 10'(x);
        wr_y     = 10'(y);
        wr_scale = 8'(sc);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // cyc counts cycles from the frame_start cycle to the frame_done cycle.
    task automatic run_frame(input int inj, output int cyc);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        cyc = 1;
        while (!frame_done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            frame_start = (cyc == inj);
        end
        frame_start = 1'b0;
        chk("frame_done_seen", frame_done, 1);
    endtask

    initial begin
        int cyc;
        int b_rrst;
        int b_ren;
        int b_done;
        int nq;

        rst         = 1'b0;
        frame_start = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_valid    = 1'b0;
        wr_id       = '0;
        wr_x        = '0;
        wr_y        = '0;
        wr_scale    = '0;
        repeat (3) @(negedge clk);

        chk("rst_render_rst", render_rst, 0);
        chk("rst_render_en", render_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_drawn", sprites_drawn, 0);
        chk("rst_spr_x", spr_x, 0);
        rst = 1'b1;

        // 1: empty table
        b_rrst = n_rrst;
        run_frame(0, cyc);
        chk("t1_cycles", cyc, 2 * N + 1);
        chk("t1_drawn", sprites_drawn, 0);
        chk("t1_no_rrst", n_rrst - b_rrst, 0);
        chk("t1_busy", busy, 0);

        // 2: single sprite, 256-cycle render
        write_entry(3, 1'b1, 2, 100, 50, 16);
        rlat   = 256;
        b_rrst = n_rrst;
        b_ren  = n_ren;
        nq     = qx.size();
        run_frame(0, cyc);
        chk("t2_rrst", n_rrst - b_rrst, 1);
        chk("t2_en_cycles", n_ren - b_ren, 256);
        chk("t2_x", qx[nq], 100);
        chk("t2_y", qy[nq], 50);
        chk("t2_id", qid[nq], 2);
        chk("t2_drawn", sprites_drawn, 1);
        chk("t2_cycles", cyc, 2 * N + 1 + 1 + 256);
        chk("t2_hold_x", spr_x, 100);

        // 3: first and last entries
        write_entry(3, 1'b0, 0, 0, 0, 0);
        write_entry(0, 1'b1, 1, 10, 5, 8);
        write_entry(15, 1'b1, 3, 20, 6, 8);
        rlat   = 8;
        b_rrst = n_rrst;
        b_done = n_done;
        nq     = qx.size();
        run_frame(0, cyc);
        @(negedge clk);
        chk("t3_rrst", n_rrst - b_rrst, 2);
        chk("t3_first_x", qx[nq], 10);
        chk("t3_second_x", qx[nq+1], 20);
        chk("t3_done_once", n_done - b_done, 1);
        chk("t3_busy", busy, 0);
        chk("t3_drawn", sprites_drawn, 2);
        chk("t3_cycles", cyc, 2 * N + 1 + 2 * (1 + 8));

        // 4: scale 0 skipped, overrun on mid-walk frame_start
        write_entry(0, 1'b0, 0, 0, 0, 0);
        write_entry(15, 1'b0, 0, 0, 0, 0);
        write_entry(5, 1'b1, 1, 40, 40, 0);
        chk("t4_overrun_pre", overrun, 0);
        b_rrst = n_rrst;
        b_done = n_done;
        run_frame(10, cyc);
        @(negedge clk);
        chk("t4_overrun", overrun, 1);
        chk("t4_no_rrst", n_rrst - b_rrst, 0);
        chk("t4_cycles", cyc, 2 * N + 1);
        chk("t4_done_once", n_done - b_done, 1);
        chk("t4_busy", busy, 0);

        // 5: overwrite entry while it is being drawn
        write_entry(5, 1'b0, 0, 0, 0, 0);
        write_entry(2, 1'b1, 1, 200, 60, 4);
        rlat = 20;
        nq   = qx.size();
        fork
            run_frame(0, cyc);
            begin
                for (int k = 0; k < 200 && !render_en; k++) @(negedge clk);
                write_entry(2, 1'b1, 1, 300, 60, 4);
                chk("t5_still_draw", render_en, 1);
                chk("t5_hold_x", spr_x, 200);
            end
        join
        chk("t5_issued_old", qx[nq], 200);
        run_frame(0, cyc);
        chk("t5_issued_new", qx[nq+1], 300);

        // 6a: off-screen entry
        write_entry(2, 1'b0, 0, 0, 0, 0);
        write_entry(7, 1'b1, 4, 820, 10, 16);
        rlat   = 30;
        b_rrst = n_rrst;
        nq     = qx.size();
        run_frame(0, cyc);
`ifdef SPRITE_SCHED_CULL_EN
        chk("t6_culled_rrst", n_rrst - b_rrst, 0);
        chk("t6_culled_cycles", cyc, 2 * N + 1);
`else
        chk("t6_issued_rrst", n_rrst - b_rrst, 1);
        chk("t6_issued_x", qx[nq], 820);
        chk("t6_issued_cycles", cyc, 2 * N + 1 + 1 + 30);
`endif

        // 6b: reset during DRAW
        write_entry(8, 1'b1, 5, 100, 100, 16);
        rlat = 1000;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int k = 0; k < 500 && !render_en; k++) @(negedge clk);
        chk("t6_draw_reached", render_en, 1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_en", render_en, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rrst", render_rst, 0);
        chk("t6_rst_overrun", overrun, 0);
        chk("t6_rst_drawn", sprites_drawn, 0);
        rst = 1'b1;
        b_rrst = n_rrst;
        run_frame(0, cyc);
        chk("t6_table_cleared", n_rrst - b_rrst, 0);
        chk("t6_post_cycles", cyc, 2 * N + 1);

        chk("rrst_en_overlap", n_ovl, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
